// File: rtl/serial_subtractor_64.sv
// serial_subtractor_64
//   Digit-serial subtractor: diff = a - b - borrow_in (mod 2^WIDTH), CHUNK bits
//   per clock. Operands enter over a valid/ready handshake; the result and its
//   borrow / signed-overflow / zero flags leave over a second valid/ready
//   handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands valid                 in_ready   block can accept operands
//   a          minuend   [WIDTH]              b          subtrahend [WIDTH]
//   borrow_in  borrow into bit 0
//   out_valid  result valid                   out_ready  consumer accepts result
//   diff       a - b - borrow_in [WIDTH]
//   borrow_out unsigned a < b + borrow_in     overflow   signed two's-complement overflow
//   zero       diff == 0
module serial_subtractor_64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("serial_subtractor_64: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;       // shifts right one chunk per RUN edge
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;     // working result, filled from the top
  logic             borrow_q;
  logic             a_msb_q;   // sign bits kept for the overflow flag
  logic             b_msb_q;
  logic [CNT_W-1:0] idx_q;

  logic [CHUNK:0]   step;      // {borrow, chunk difference}
  logic [WIDTH-1:0] res_next;

  // Subtract one chunk as x + ~y + ~bin; the borrow is the inverted carry.
  function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             bin);
    logic [CHUNK:0] s;
    s = {1'b0, x} + {1'b0, ~y} + {{CHUNK{1'b0}}, ~bin};
    return {~s[CHUNK], s[CHUNK-1:0]};
  endfunction

  assign step     = sub_chunk(a_q[CHUNK-1:0], b_q[CHUNK-1:0], borrow_q);
  assign res_next = {step[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      idx_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= borrow_in;
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
            res_q    <= '0;
            idx_q    <= '0;
            state    <= RUN;
          end
        end
        // one chunk per edge, least significant first
        RUN: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          borrow_q <= step[CHUNK];
          res_q    <= res_next;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            // output registers only change here, so they hold across the next RUN
            diff       <= res_next;
            borrow_out <= step[CHUNK];
            zero       <= ~|res_next;
            overflow   <= (a_msb_q ^ b_msb_q) & (res_next[WIDTH-1] ^ a_msb_q);
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_64.sv
module tb_serial_subtractor_64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        borrow_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  int errors = 0;
  int checks = 0;

  serial_subtractor_64 #(.WIDTH(64), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Present operands for one edge (block assumed idle), leave at #1 after accept.
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic bi);
    a = av; b = bv; borrow_in = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; gives up after 20.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({diff, borrow_out, overflow, zero} !== 67'd0) begin errors++;
      $display("FAIL reset_outputs got diff=%h b=%b o=%b z=%b exp all 0", diff, borrow_out, overflow, zero); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    send(64'd5, 64'd3, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy in_ready got=%b exp=0", in_ready); end
    wait_result(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (diff !== 64'd2) begin errors++; $display("FAIL basic_diff got=%h exp=2", diff); end
    checks++; if ({borrow_out, overflow, zero} !== 3'b000) begin errors++;
      $display("FAIL basic_flags got bof/ovf/zero=%b%b%b exp=000", borrow_out, overflow, zero); end
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL basic_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_wrap_zero();
    int lat;
    send(64'd0, 64'd1, 1'b0);
    wait_result(lat);
    checks++; if (diff !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_diff got=%h exp=ffffffffffffffff", diff); end
    checks++; if ({borrow_out, overflow, zero} !== 3'b100) begin errors++;
      $display("FAIL wrap_flags got=%b%b%b exp=100", borrow_out, overflow, zero); end
    release_result();
    send(64'h1234, 64'h1234, 1'b0);
    wait_result(lat);
    checks++; if (diff !== 64'd0) begin errors++; $display("FAIL zero_diff got=%h exp=0", diff); end
    checks++; if ({borrow_out, overflow, zero} !== 3'b001) begin errors++;
      $display("FAIL zero_flags got=%b%b%b exp=001", borrow_out, overflow, zero); end
    release_result();
  endtask

  task automatic test_borrow_overflow();
    int lat;
    send(64'h1234, 64'h1234, 1'b1);
    wait_result(lat);
    checks++; if (diff !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL bin_diff got=%h exp=ffffffffffffffff", diff); end
    checks++; if ({borrow_out, overflow, zero} !== 3'b100) begin errors++;
      $display("FAIL bin_flags got=%b%b%b exp=100", borrow_out, overflow, zero); end
    release_result();
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
    wait_result(lat);
    checks++; if (diff !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ovf_diff got=%h exp=7fffffffffffffff", diff); end
    checks++; if ({borrow_out, overflow, zero} !== 3'b010) begin errors++;
      $display("FAIL ovf_flags got=%b%b%b exp=010", borrow_out, overflow, zero); end
    release_result();
  endtask

  task automatic test_cross_chunk();
    int lat;
    send(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b0);
    wait_result(lat);
    checks++; if (diff !== 64'h0000_0000_0000_00FF) begin errors++; $display("FAIL xchunk1_diff got=%h exp=ff", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL xchunk1_borrow got=%b exp=0", borrow_out); end
    release_result();
    send(64'h0, 64'h0000_0001_0000_0000, 1'b0);
    wait_result(lat);
    checks++; if (diff !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL xchunk2_diff got=%h exp=ffffffff00000000", diff); end
    checks++; if ({borrow_out, overflow, zero} !== 3'b100) begin errors++;
      $display("FAIL xchunk2_flags got=%b%b%b exp=100", borrow_out, overflow, zero); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(64'd100, 64'd1, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      a = 64'd50; b = 64'd8; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
        $display("FAIL hold_ctrl cyc=%0d got out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready); end
      checks++; if (diff !== 64'd99 || {borrow_out, overflow, zero} !== 3'b000) begin errors++;
        $display("FAIL hold_data cyc=%0d got diff=%h flags=%b%b%b exp 63/000", i, diff, borrow_out, overflow, zero); end
    end
    a = 64'd20; b = 64'd7; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_handshake got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got=%b exp=0", in_ready); end
    wait_result(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    checks++; if (diff !== 64'd13) begin errors++; $display("FAIL b2b_diff got=%h exp=d", diff); end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    send(64'hFFFF, 64'h1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_ctrl got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    checks++; if ({diff, borrow_out, overflow, zero} !== 67'd0) begin errors++;
      $display("FAIL midrst_outputs got diff=%h flags=%b%b%b exp all 0", diff, borrow_out, overflow, zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    send(64'd9, 64'd4, 1'b0);
    wait_result(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_latency got=%0d exp=8", lat); end
    checks++; if (diff !== 64'd5 || zero !== 1'b0) begin errors++;
      $display("FAIL midrst_diff got=%h zero=%b exp=5 zero=0", diff, zero); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_zero();
    test_borrow_overflow();
    test_cross_chunk();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_64.md
Name: serial_subtractor_64

Overview:
- Multi-cycle, digit-serial subtractor. Computes diff = a - b - borrow_in over WIDTH bits, processing CHUNK bits per clock.
- Complement of the team's combinational ripple adder. Used where area matters more than latency, e.g. the ALU's shared slow path.
- Operands are accepted over a valid/ready input handshake. Results are returned over a valid/ready output handshake and include borrow, signed-overflow and zero flags.

Parameters:
- WIDTH, 64, operand and result width in bits.
- CHUNK, 8, bits subtracted per clock. WIDTH % CHUNK must be 0; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  borrow into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  1 iff unsigned a < b + borrow_in.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  diff == 0.

Behaviour:
- Reset (async assert, any state): state=IDLE; in_ready=1; out_valid=0; diff=0; borrow_out=0; overflow=0; zero=0; internal operand and chunk registers cleared. Outputs take these values immediately on assertion.
- N = WIDTH/CHUNK (8 at defaults).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clk edge: capture a, b and borrow_in; chunk index=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes chunk k, bits [k*CHUNK +: CHUNK]: diff chunk = a_k + ~b_k + ~borrow. The internal borrow register carries into the next chunk.
  - After chunk N-1: latch borrow_out, overflow and zero; go to DONE.
  - Exactly N edges in RUN.
- DONE:
  - out_valid=1; diff and flags are stable and held.
  - On out_ready at an edge: go to IDLE; out_valid=0 after that edge. diff and flags keep their last values until the next RUN completes.
- Latency: accept at edge T. out_valid is high after edge T+N and remains high until the out handshake.
- Throughput: at most one operation per N+2 cycles. The next accept is possible on the edge after the out handshake, since in_ready rises in IDLE.
- in_valid while in_ready=0 is ignored. Operands are not re-sampled; the upstream holds until the handshake.
- out_ready while out_valid=0 has no effect.
- Flags:
  - borrow_out = final borrow out of the MSB.
  - overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]). Uses the captured a and b. borrow_in is included in diff.
  - zero = ~|diff.
- Wrap-around: the result is modulo 2^WIDTH, e.g. 0 - 1 = all ones with borrow_out=1.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no result is produced, and the block returns to IDLE.
- Combinational paths: none from inputs to outputs. in_ready and out_valid decode state only.

Test Plan:
1. Basic subtract: a=5, b=3, borrow_in=0 accepted at edge T -> out_valid rises after edge T+8; diff=2, borrow_out=0, overflow=0, zero=0.
2. Wrap and zero: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow_out=1, overflow=0. Then a=b=0x1234, borrow_in=0 -> diff=0, zero=1, borrow_out=0.
3. Borrow-in and signed overflow: a=b=0x1234, borrow_in=1 -> diff=all ones, borrow_out=1. Then a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, overflow=1, borrow_out=0.
4. Cross-chunk borrow propagation: a=0x0000_0000_0000_0100, b=0x0000_0000_0000_0001 -> diff=0x0000_0000_0000_00FF. Then a=0x1_0000_0000_0000_0000 truncated to 0, b=0x0000_0001_0000_0000 -> diff=0xFFFF_FFFF_0000_0000, borrow_out=1.
5. Backpressure and back-to-back: hold out_ready=0 for 5 cycles in DONE -> out_valid, diff and flags stable, in_ready=0, and a pulsing in_valid is not accepted. Raise out_ready with in_valid held -> next operands accepted on the following edge, and the second result is correct.
6. Reset mid-operation: assert rst 3 edges into RUN -> out_valid=0, diff=0 and all flags 0 immediately. Release rst -> in_ready=1; a new operation 9-4 completes with diff=5 after 8 RUN edges.
